// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - shared register offsets, reset values and decode for the machine timer
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hbff8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hbffc;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI,
        REG_NONE
    } clint_reg_e;

    function automatic clint_reg_e clint_decode(input logic [15:0] off);
        case (off)
            CLINT_MSIP:        return REG_MSIP;
            CLINT_MTIMECMP_LO: return REG_CMP_LO;
            CLINT_MTIMECMP_HI: return REG_CMP_HI;
            CLINT_MTIME_LO:    return REG_TIME_LO;
            CLINT_MTIME_HI:    return REG_TIME_HI;
            default:           return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/clint_timer_if.sv
// rtl/clint_timer_if.sv - core data bus slice seen by the machine timer
interface clint_timer_if;
    logic        mem_valid;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] rdata;
    logic        rhit;

    modport master (
        output mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
        input  rdata, rhit
    );

    modport slave (
        input  mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
        output rdata, rhit
    );
endinterface

// File: rtl/clint_prescaler.sv
// rtl/clint_prescaler.sv - free-running divider producing one mtime tick every PRESCALE cycles
module clint_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rstn,
    output logic tick
);

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [15:0] pre;

    assign tick = (pre == PRE_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 16'd1;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - memory-mapped mtime/mtimecmp/msip with registered timer and soft irqs
module clint_timer
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4400_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic          clk,
    input  logic          rstn,
    clint_timer_if.slave  bus,
    output logic          irq_timer,
    output logic          irq_soft
);

    logic        tick;
    logic        hit;
    logic        wr_en;
    clint_reg_e  sel;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic [31:0] rd_mux;

    clint_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rstn (rstn),
        .tick (tick)
    );

    assign hit   = bus.mem_valid && (bus.mem_addr[31:16] == BASE_ADDR[31:16]);
    assign sel   = clint_decode(bus.mem_addr[15:0]);
    assign wr_en = hit && bus.mem_write && (bus.mem_wmask == 4'b1111);

    // A bus write to one mtime half overrides the tick and does not carry into the other half.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mtime <= '0;
        end else if (wr_en && sel == REG_TIME_LO) begin
            mtime <= {mtime[63:32], bus.mem_wdata};
        end else if (wr_en && sel == REG_TIME_HI) begin
            mtime <= {bus.mem_wdata, mtime[31:0]};
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mtimecmp <= MTIMECMP_RESET;
            msip     <= 1'b0;
        end else if (wr_en) begin
            case (sel)
                REG_CMP_LO: mtimecmp[31:0]  <= bus.mem_wdata;
                REG_CMP_HI: mtimecmp[63:32] <= bus.mem_wdata;
                REG_MSIP:   msip            <= bus.mem_wdata[0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        rd_mux = 32'hFFFF_FFFF;
        case (sel)
            REG_MSIP:    rd_mux = {31'b0, msip};
            REG_CMP_LO:  rd_mux = mtimecmp[31:0];
            REG_CMP_HI:  rd_mux = mtimecmp[63:32];
            REG_TIME_LO: rd_mux = mtime[31:0];
            REG_TIME_HI: rd_mux = mtime[63:32];
            default:     rd_mux = 32'hFFFF_FFFF;
        endcase
    end

    // Read data samples pre-write register values, so a same-cycle write is not forwarded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.rdata <= '0;
            bus.rhit  <= 1'b0;
            irq_timer <= 1'b0;
            irq_soft  <= 1'b0;
        end else begin
            bus.rhit  <= hit;
            bus.rdata <= hit ? rd_mux : 32'h0;
            irq_timer <= (mtime >= mtimecmp);
            irq_soft  <= msip;
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - directed self-checking bench for clint_timer at PRESCALE 1 and 4
module tb_clint_timer;

    localparam logic [31:0] A1 = 32'h4400_0000;
    localparam logic [31:0] A4 = 32'h4500_0000;

    logic clk;
    logic rstn;
    logic irq_timer1, irq_soft1, irq_timer4, irq_soft4;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] d;
    logic        h;

    clint_timer_if bus1 ();
    clint_timer_if bus4 ();

    assign bus4.mem_valid = bus1.mem_valid;
    assign bus4.mem_write = bus1.mem_write;
    assign bus4.mem_wmask = bus1.mem_wmask;
    assign bus4.mem_wdata = bus1.mem_wdata;
    assign bus4.mem_addr  = bus1.mem_addr;

    clint_timer #(.BASE_ADDR(A1), .PRESCALE(1)) dut1 (
        .clk(clk), .rstn(rstn), .bus(bus1), .irq_timer(irq_timer1), .irq_soft(irq_soft1)
    );

    clint_timer #(.BASE_ADDR(A4), .PRESCALE(4)) dut4 (
        .clk(clk), .rstn(rstn), .bus(bus4), .irq_timer(irq_timer4), .irq_soft(irq_soft4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        bus1.mem_valid = 1'b1;
        bus1.mem_write = 1'b1;
        bus1.mem_wmask = mask;
        bus1.mem_wdata = data;
        bus1.mem_addr  = addr;
        @(posedge clk);
        #1;
        bus1.mem_valid = 1'b0;
        bus1.mem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic hit);
        bus1.mem_valid = 1'b1;
        bus1.mem_write = 1'b0;
        bus1.mem_addr  = addr;
        @(posedge clk);
        #1;
        if (addr[31:16] == A4[31:16]) begin
            data = bus4.rdata;
            hit  = bus4.rhit;
        end else begin
            data = bus1.rdata;
            hit  = bus1.rhit;
        end
        bus1.mem_valid = 1'b0;
    endtask

    initial begin
        rstn           = 1'b0;
        bus1.mem_valid = 1'b0;
        bus1.mem_write = 1'b0;
        bus1.mem_wmask = 4'h0;
        bus1.mem_wdata = 32'h0;
        bus1.mem_addr  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rhit", {63'b0, bus1.rhit}, 64'd0);
        chk("reset_rdata", {32'b0, bus1.rdata}, 64'd0);
        chk("reset_irq_timer", {63'b0, irq_timer1}, 64'd0);
        chk("reset_irq_soft", {63'b0, irq_soft1}, 64'd0);
        rstn = 1'b1;

        // mtime counts one per cycle from zero
        rd(A1 + 32'hbff8, d, h);
        chk("mtime_first", {32'b0, d}, 64'd0);
        chk("mtime_rhit", {63'b0, h}, 64'd1);
        rd(A1 + 32'hbff8, d, h);
        chk("mtime_second", {32'b0, d}, 64'd1);
        rd(A1 + 32'hbff8, d, h);
        chk("mtime_third", {32'b0, d}, 64'd2);
        chk("no_irq_cmp_ones", {63'b0, irq_timer1}, 64'd0);

        // compare at 100
        wr(A1 + 32'h4004, 32'd0, 4'hf);
        wr(A1 + 32'h4000, 32'd100, 4'hf);
        wr(A1 + 32'hbff8, 32'd90, 4'hf);
        repeat (10) @(posedge clk);
        #1;
        chk("irq_before_100", {63'b0, irq_timer1}, 64'd0);
        @(posedge clk);
        #1;
        chk("irq_at_100", {63'b0, irq_timer1}, 64'd1);
        wr(A1 + 32'h4004, 32'd1, 4'hf);
        chk("irq_hold_after_hi_wr", {63'b0, irq_timer1}, 64'd1);
        @(posedge clk);
        #1;
        chk("irq_drop_hi_1", {63'b0, irq_timer1}, 64'd0);

        // 64-bit wrap
        wr(A1 + 32'h4004, 32'd0, 4'hf);
        wr(A1 + 32'h4000, 32'd5, 4'hf);
        wr(A1 + 32'hbffc, 32'hFFFF_FFFF, 4'hf);
        wr(A1 + 32'hbff8, 32'hFFFF_FFFE, 4'hf);
        chk("wrap_irq_high", {63'b0, irq_timer1}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_irq_still_high", {63'b0, irq_timer1}, 64'd1);
        @(posedge clk);
        #1;
        chk("wrap_irq_drop", {63'b0, irq_timer1}, 64'd0);
        rd(A1 + 32'hbffc, d, h);
        chk("wrap_mtime_hi", {32'b0, d}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("wrap_irq_before_5", {63'b0, irq_timer1}, 64'd0);
        @(posedge clk);
        #1;
        chk("wrap_irq_at_5", {63'b0, irq_timer1}, 64'd1);

        // partial writes and unmapped offsets
        wr(A1 + 32'h4000, 32'hFFFF_FFFF, 4'hf);
        wr(A1 + 32'h4004, 32'hFFFF_FFFF, 4'hf);
        wr(A1 + 32'h4004, 32'h0, 4'b0001);
        wr(A1 + 32'h4000, 32'h0, 4'b0001);
        rd(A1 + 32'h4004, d, h);
        chk("partial_cmp_hi", {32'b0, d}, 64'hFFFF_FFFF);
        rd(A1 + 32'h4000, d, h);
        chk("partial_cmp_lo", {32'b0, d}, 64'hFFFF_FFFF);
        chk("partial_no_irq", {63'b0, irq_timer1}, 64'd0);
        wr(A1 + 32'h0008, 32'h1, 4'hf);
        rd(A1 + 32'h0008, d, h);
        chk("unmapped_rdata", {32'b0, d}, 64'hFFFF_FFFF);
        chk("unmapped_rhit", {63'b0, h}, 64'd1);
        rd(A1 + 32'h0000, d, h);
        chk("unmapped_wr_dropped", {32'b0, d}, 64'd0);
        @(posedge clk);
        #1;
        chk("idle_rhit", {63'b0, bus1.rhit}, 64'd0);
        rd(32'h4600_0000, d, h);
        chk("out_of_region_rhit1", {63'b0, h}, 64'd0);
        chk("out_of_region_rhit4", {63'b0, bus4.rhit}, 64'd0);

        // software interrupt
        wr(A1 + 32'h0000, 32'h1, 4'hf);
        chk("irq_soft_n1", {63'b0, irq_soft1}, 64'd0);
        @(posedge clk);
        #1;
        chk("irq_soft_n2", {63'b0, irq_soft1}, 64'd1);

        // asynchronous reset mid-cycle
        wr(A1 + 32'h4000, 32'h0, 4'hf);
        wr(A1 + 32'h4004, 32'h0, 4'hf);
        @(posedge clk);
        #1;
        chk("pre_reset_irq_timer", {63'b0, irq_timer1}, 64'd1);
        rd(A1 + 32'h0000, d, h);
        chk("pre_reset_msip", {32'b0, d}, 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rhit", {63'b0, bus1.rhit}, 64'd0);
        chk("async_rdata", {32'b0, bus1.rdata}, 64'd0);
        chk("async_irq_timer", {63'b0, irq_timer1}, 64'd0);
        chk("async_irq_soft", {63'b0, irq_soft1}, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // PRESCALE=4: ticks on the 4th, 8th, 12th edge after release
        wr(A4 + 32'hbffc, 32'd7, 4'hf);
        repeat (2) @(posedge clk);
        #1;
        wr(A4 + 32'hbff8, 32'd10, 4'hf);
        rd(A4 + 32'hbff8, d, h);
        chk("pre4_tick_write_lo", {32'b0, d}, 64'd10);
        rd(A4 + 32'hbffc, d, h);
        chk("pre4_hi_unchanged", {32'b0, d}, 64'd7);
        rd(A4 + 32'hbff8, d, h);
        chk("pre4_hold_a", {32'b0, d}, 64'd10);
        rd(A4 + 32'hbff8, d, h);
        chk("pre4_hold_b", {32'b0, d}, 64'd10);
        rd(A4 + 32'hbff8, d, h);
        chk("pre4_step_11", {32'b0, d}, 64'd11);
        repeat (3) @(posedge clk);
        #1;
        rd(A4 + 32'hbff8, d, h);
        chk("pre4_step_12", {32'b0, d}, 64'd12);

        rd(A1 + 32'h4000, d, h);
        chk("post_reset_cmp_lo", {32'b0, d}, 64'hFFFF_FFFF);
        rd(A1 + 32'h4004, d, h);
        chk("post_reset_cmp_hi", {32'b0, d}, 64'hFFFF_FFFF);
        rd(A1 + 32'h0000, d, h);
        chk("post_reset_msip", {32'b0, d}, 64'd0);
        chk("post_reset_irq_soft", {63'b0, irq_soft1}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clint_timer.md
# clint_timer

Memory-mapped machine timer and software-interrupt unit on the core data bus, directly upstream of the Pipeline's `irq_timer` input. It holds the 64-bit `mtime` counter with a prescaler, the 64-bit `mtimecmp` register and the `msip` bit. It drives registered `irq_timer`/`irq_soft` levels. Bus reads return data one cycle after the request, matching the synchronous memories on the same bus.

## Interface
- `BASE_ADDR`, default 32'h4400_0000: region base; decoded on `mem_addr[31:16]`.
- `PRESCALE`, default 1: `clk` cycles per `mtime` increment; legal range 1..65535.
- `clk` in 1: core clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `mem_valid` in 1: bus request.
- `mem_write` in 1: write request when `mem_valid`.
- `mem_wmask` in 4: byte enables.
- `mem_wdata` in 32: write data.
- `mem_addr` in 32: byte address.
- `rdata` out 32: read data for the previous cycle's address.
- `rhit` out 1: previous-cycle `mem_valid` hit a mapped register. The bus mux selects `rdata` on this.
- `irq_timer` out 1: registered level, `mtime >= mtimecmp`.
- `irq_soft` out 1: registered level, copy of `msip`.

## Operation
- Register map (offsets from `BASE_ADDR`):
  - 0x0000 `msip`: bit 0 only; reads return zero-extended.
  - 0x4000 `mtimecmp[31:0]`
  - 0x4004 `mtimecmp[63:32]`
  - 0xbff8 `mtime[31:0]`
  - 0xbffc `mtime[63:32]`
- Any other offset in the region reads ~0 with `rhit`=1; writes to it are dropped.
- Writes take effect only when `mem_valid & mem_write & mem_wmask==4'b1111`. Partial writes are ignored silently and have no side effect.
- Prescaler: counter `pre` runs 0..PRESCALE-1. A tick occurs in the cycle where `pre==PRESCALE-1`, then `pre` returns to 0. With PRESCALE=1 every cycle is a tick.
- On a tick, `mtime <= mtime+1`, 64-bit, wrapping from 2^64-1 to 0.
- A bus write to either `mtime` half in a tick cycle wins. The written half takes the bus data; the other half keeps its old value, so there is no carry into it. `pre` is not reset by the write.
- Comparison: unsigned 64-bit on the current register values. `irq_timer <= (mtime >= mtimecmp)` every cycle.
- Software updates the two halves separately. A transient match between the two writes is architecturally allowed and is not filtered.
- `irq_soft <= msip` every cycle.
- Reset values:
  - `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, `pre`=0.
  - `irq_timer`=0, `irq_soft`=0, `rdata`=0, `rhit`=0.
- Reset asserted mid-operation clears all state immediately, asynchronously. No pending write survives reset.

## Timing
- Read latency is 1 cycle. `rdata`/`rhit` are registered from the cycle-N address and register values and are valid in cycle N+1.
- Read and write to the same register in the same cycle: `rdata` returns the old value.
- Write in cycle N is visible to a read issued in cycle N+1.
- `irq_timer` latency is 1 cycle after the compare condition becomes true or false. Example: a write making `mtimecmp` ≤ `mtime` in cycle N gives `irq_timer`=1 from cycle N+2, because the register updates at end of N and compare/flop happens in N+1.
- `irq_soft` follows a `msip` write with the same N+2 timing.
- `rhit` is 0 in any cycle after `mem_valid`=0 or an out-of-region address.
- No backpressure. The block accepts a request every cycle.

## Structure
- Shared package `clint_pkg`:
  - offset constants `CLINT_MSIP`, `CLINT_MTIMECMP_LO/HI`, `CLINT_MTIME_LO/HI`
  - reset constant `MTIMECMP_RESET`
- Optional sub-module `clint_prescaler`: counter plus `tick` output.
- Everything else is flat: decode, registers, compare and read mux, about 150–200 lines.

## Test plan
- Reset, then poll `mtime_lo` with PRESCALE=1: read at cycle k after release returns k−1±const, strictly incrementing by 1 per cycle. `irq_timer` stays 0 because `mtimecmp` is all ones.
- Write `mtimecmp`={0, 100}, hi first then lo: `irq_timer` rises exactly 2 cycles after `mtime` reaches 100. Writing `mtimecmp_hi`=1 drops it 2 cycles later.
- Write `mtime`={32'hFFFF_FFFF, 32'hFFFF_FFFE}, `mtimecmp`={0, 5}: `irq_timer`=1, then `mtime` wraps to 0 after 2 ticks, `irq_timer` drops, and reasserts when `mtime`=5.
- Byte write (wmask=4'b0001) to `mtimecmp_lo` of 0: the value is unchanged on readback and there is no irq. A write to offset 0x0008 is dropped, and a read there returns 32'hFFFF_FFFF with `rhit`=1.
- PRESCALE=4: `mtime` advances 1 per 4 cycles. A `mtime_lo`=10 write on a tick cycle reads back 10, not 11, and the hi half is unchanged.
- Write `msip`=1: `irq_soft`=1 two cycles later. Assert `rstn`=0 asynchronously mid-cycle: all outputs go to 0 immediately and `mtimecmp` reads back all ones after release.
